// File: rtl/i2c_pkg.sv
// i2c_pkg: shared I2C state encoding, ACK/NACK levels and R/W bit encoding.
package i2c_pkg;
  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK,
    ST_WAIT_STOP
  } slv_state_t;
  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;
  localparam logic I2C_RD   = 1'b1;
  // open-drain: pull the line low exactly when the bit to present is 0
  function automatic logic pull(input logic b);
    return b == I2C_ACK;
  endfunction
endpackage

// File: rtl/i2c_bus_sync.sv
// i2c_bus_sync: 2-FF synchronizer for SCL/SDA plus one stage for edge and START/STOP detection.
module i2c_bus_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);
  logic [2:0] scl_q, sda_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      scl_q <= '1;
      sda_q <= '1;
    end else begin
      scl_q <= {scl_q[1:0], scl_i};
      sda_q <= {sda_q[1:0], sda_i};
    end
  assign scl_rise  = scl_q[1] & ~scl_q[2];
  assign scl_fall  = ~scl_q[1] & scl_q[2];
  assign start_det = scl_q[1] & scl_q[2] & ~sda_q[1] & sda_q[2];
  assign stop_det  = scl_q[1] & scl_q[2] & sda_q[1] & ~sda_q[2];
  assign sda_s     = sda_q[1];
endmodule

// File: rtl/i2c_slave_regfile.sv
// i2c_slave_regfile: I2C slave with pointer-addressed register file and open-drain SDA.
// Define I2C_SLV_AUTOINC_EN to advance the pointer after each written byte and each master-ACKed read byte.
module i2c_slave_regfile
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h2A,
  parameter int         NUM_REGS   = 16,
  parameter int         PTR_W      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             scl_i,
  input  logic             sda_i,
  output logic             sda_oe,
  input  logic [PTR_W-1:0] loc_addr,
  output logic [7:0]       loc_rdata,
  output logic             wr_evt,
  output logic [PTR_W-1:0] wr_evt_idx,
  output logic             busy
);
  slv_state_t       state;
  logic [7:0]       regs [NUM_REGS];
  logic [7:0]       shift, rx_byte;
  logic [2:0]       bitcnt;
  logic [PTR_W-1:0] ptr, ptr_nxt;
  logic             rw, byte_done;
  logic             scl_rise, scl_fall, start_det, stop_det, sda_s;

  i2c_bus_sync u_sync (
    .clk(clk),
    .rst_n(rst_n),
    .scl_i(scl_i),
    .sda_i(sda_i),
    .scl_rise(scl_rise),
    .scl_fall(scl_fall),
    .start_det(start_det),
    .stop_det(stop_det),
    .sda_s(sda_s)
  );

  assign rx_byte   = {shift[6:0], sda_s};
  assign loc_rdata = regs[loc_addr];
`ifdef I2C_SLV_AUTOINC_EN
  assign ptr_nxt = ptr + 1'b1;
`else
  assign ptr_nxt = ptr;
`endif

  // byte_done marks a completed byte (or master ACK) whose response is issued on the next SCL fall
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= ST_IDLE;
      shift      <= '0;
      bitcnt     <= '0;
      ptr        <= '0;
      rw         <= 1'b0;
      byte_done  <= 1'b0;
      sda_oe     <= 1'b0;
      busy       <= 1'b0;
      wr_evt     <= 1'b0;
      wr_evt_idx <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      wr_evt <= 1'b0;
      if (start_det) begin
        state     <= ST_ADDR;
        bitcnt    <= 3'd7;
        byte_done <= 1'b0;
        sda_oe    <= 1'b0;
        busy      <= 1'b0;
      end else if (stop_det) begin
        state     <= ST_IDLE;
        byte_done <= 1'b0;
        sda_oe    <= 1'b0;
        busy      <= 1'b0;
      end else if (scl_rise) begin
        case (state)
          ST_ADDR, ST_PTR, ST_WDATA: begin
            shift  <= rx_byte;
            bitcnt <= bitcnt - 3'd1;
            if (bitcnt == 3'd0) begin
              byte_done <= state != ST_ADDR || rx_byte[7:1] == SLAVE_ADDR;
              if (state == ST_ADDR) begin
                rw <= rx_byte[0];
                if (rx_byte[7:1] != SLAVE_ADDR) state <= ST_WAIT_STOP;
              end else if (state == ST_PTR) begin
                ptr <= rx_byte[PTR_W-1:0];
              end else begin
                regs[ptr]  <= rx_byte;
                wr_evt     <= 1'b1;
                wr_evt_idx <= ptr;
                ptr        <= ptr_nxt;
              end
            end
          end
          ST_RDATA: begin
            bitcnt <= bitcnt - 3'd1;
            if (bitcnt == 3'd0) byte_done <= 1'b1;
          end
          ST_RDATA_ACK:
            if (sda_s == I2C_NACK) state <= ST_WAIT_STOP;
            else begin
              ptr       <= ptr_nxt;
              byte_done <= 1'b1;
            end
          default: ;
        endcase
      end else if (scl_fall) begin
        case (state)
          ST_ADDR, ST_PTR, ST_WDATA:
            if (byte_done) begin
              byte_done <= 1'b0;
              sda_oe    <= pull(I2C_ACK);
              busy      <= 1'b1;
              state     <= state == ST_ADDR ? ST_ADDR_ACK : state == ST_PTR ? ST_PTR_ACK : ST_WDATA_ACK;
            end
          ST_ADDR_ACK: begin
            bitcnt <= 3'd7;
            if (rw == I2C_RD) begin
              state  <= ST_RDATA;
              shift  <= regs[ptr];
              sda_oe <= pull(regs[ptr][7]);
            end else begin
              state  <= ST_PTR;
              sda_oe <= 1'b0;
            end
          end
          ST_PTR_ACK, ST_WDATA_ACK: begin
            state  <= ST_WDATA;
            bitcnt <= 3'd7;
            sda_oe <= 1'b0;
          end
          ST_RDATA:
            if (byte_done) begin
              byte_done <= 1'b0;
              sda_oe    <= 1'b0;
              state     <= ST_RDATA_ACK;
            end else begin
              shift  <= {shift[6:0], 1'b0};
              sda_oe <= pull(shift[6]);
            end
          ST_RDATA_ACK:
            if (byte_done) begin
              byte_done <= 1'b0;
              shift     <= regs[ptr];
              sda_oe    <= pull(regs[ptr][7]);
              bitcnt    <= 3'd7;
              state     <= ST_RDATA;
            end
          default: ;
        endcase
      end
    end
endmodule

// File: tb/tb_i2c_slave_regfile.sv
// tb_i2c_slave_regfile: bus-level master model driving random register transactions against a reference register array.
module tb_i2c_slave_regfile;
`ifdef I2C_SLV_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif
  logic       clk = 1'b0, rst_n = 1'b0, scl = 1'b1, sda_m = 1'b1;
  logic [3:0] loc_addr = '0;
  logic       sda_oe, wr_evt, busy;
  logic [7:0] loc_rdata;
  logic [3:0] wr_evt_idx;
  wire        sda_line = sda_m & ~sda_oe;

  int n_checks = 0, n_fail = 0;
  int evt_cnt = 0, oe_seen = 0, oe_bad = 0, evt_wide = 0;
  logic [3:0] last_idx = '0;
  logic oe_prev = 1'b0, evt_prev = 1'b0;
  logic [7:0] mregs [16];
  int mptr = 0;
  logic [7:0] wq[$];

  always #5 clk = ~clk;

  i2c_slave_regfile dut (
    .clk(clk),
    .rst_n(rst_n),
    .scl_i(scl),
    .sda_i(sda_line),
    .sda_oe(sda_oe),
    .loc_addr(loc_addr),
    .loc_rdata(loc_rdata),
    .wr_evt(wr_evt),
    .wr_evt_idx(wr_evt_idx),
    .busy(busy)
  );

  always @(negedge clk) begin
    if (wr_evt) begin
      evt_cnt++;
      last_idx = wr_evt_idx;
    end
    if (wr_evt && evt_prev) evt_wide++;
    if (sda_oe) oe_seen++;
    if (rst_n && scl && sda_oe != oe_prev) oe_bad++;
    oe_prev  = sda_oe;
    evt_prev = wr_evt;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_bit(input logic b, output logic r);
    sda_m = b;
    wait_clk(5);
    scl = 1'b1;
    wait_clk(5);
    r = sda_line;
    wait_clk(5);
    scl = 1'b0;
    wait_clk(5);
  endtask

  task automatic i2c_start;
    sda_m = 1'b1;
    wait_clk(5);
    scl = 1'b1;
    wait_clk(5);
    sda_m = 1'b0;
    wait_clk(5);
    scl = 1'b0;
    wait_clk(5);
  endtask

  task automatic i2c_stop;
    sda_m = 1'b0;
    wait_clk(5);
    scl = 1'b1;
    wait_clk(5);
    sda_m = 1'b1;
    wait_clk(10);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bus_bit(b[i], r);
    bus_bit(1'b1, r);
    ack = ~r;
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bus_bit(1'b1, r);
      d[i] = r;
    end
    bus_bit(~mack, r);
  endtask

  task automatic rd_loc(input logic [3:0] a, output logic [7:0] d);
    loc_addr = a;
    @(negedge clk);
    d = loc_rdata;
  endtask

  task automatic check_regs(input string tag);
    logic [7:0] d;
    for (int i = 0; i < 16; i++) begin
      rd_loc(4'(i), d);
      check(tag, d, mregs[i]);
    end
  endtask

  task automatic do_write(input logic [7:0] p);
    logic a;
    int e0, exp_idx;
    e0 = evt_cnt;
    exp_idx = 0;
    i2c_start;
    write_byte(8'h54, a);
    check("w_addr_ack", a, 1);
    write_byte(p, a);
    check("w_ptr_ack", a, 1);
    mptr = p % 16;
    foreach (wq[k]) begin
      write_byte(wq[k], a);
      check("w_data_ack", a, 1);
      mregs[mptr] = wq[k];
      exp_idx = mptr;
      if (AUTOINC) mptr = (mptr + 1) % 16;
    end
    check("w_busy", busy, 1);
    i2c_stop;
    check("w_busy_end", busy, 0);
    check("w_evt_cnt", evt_cnt - e0, wq.size());
    if (wq.size() > 0) check("w_evt_idx", last_idx, exp_idx);
  endtask

  task automatic do_read(input bit set_ptr, input logic [7:0] p, input int n);
    logic a;
    logic [7:0] d;
    i2c_start;
    if (set_ptr) begin
      write_byte(8'h54, a);
      check("r_waddr_ack", a, 1);
      write_byte(p, a);
      check("r_ptr_ack", a, 1);
      mptr = p % 16;
      i2c_start;
    end
    write_byte(8'h55, a);
    check("r_addr_ack", a, 1);
    for (int k = 0; k < n; k++) begin
      read_byte(k < n - 1, d);
      check("r_data", d, mregs[mptr]);
      if (k < n - 1 && AUTOINC) mptr = (mptr + 1) % 16;
    end
    check("r_release", sda_oe, 0);
    i2c_stop;
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic a, r;
    logic [7:0] d;
    int e0, o0;
    for (int i = 0; i < 16; i++) mregs[i] = 8'h00;
    wait_clk(5);
    check("rst_sda_oe", sda_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_wr_evt", wr_evt, 0);
    check("rst_wr_evt_idx", wr_evt_idx, 0);
    rst_n = 1'b1;
    wait_clk(5);
    check_regs("rst_regs");

    // directed write then read back over the bus
    wq = {8'hA5};
    do_write(8'h03);
    rd_loc(4'd3, d);
    check("t1_reg3", d, 8'hA5);
    check("t1_idx", last_idx, 3);
    do_read(1'b1, 8'h03, 1);

    // foreign address: never driven, not busy
    e0 = evt_cnt;
    o0 = oe_seen;
    i2c_start;
    write_byte(8'h56, a);
    check("nomatch_ack", a, 0);
    check("nomatch_oe", oe_seen - o0, 0);
    check("nomatch_busy", busy, 0);
    i2c_stop;
    check("nomatch_evt", evt_cnt - e0, 0);

    // pointer wrap
    wq = {8'h11, 8'h22};
    do_write(8'h0F);
    rd_loc(4'd15, d);
    check("wrap_r15", d, AUTOINC ? 8'h11 : 8'h22);
    rd_loc(4'd0, d);
    check("wrap_r0", d, mregs[0]);

    // STOP after 4 data bits
    e0 = evt_cnt;
    i2c_start;
    write_byte(8'h54, a);
    write_byte(8'h05, a);
    mptr = 5;
    for (int i = 0; i < 4; i++) bus_bit(1'($urandom), r);
    i2c_stop;
    check("abort_evt", evt_cnt - e0, 0);
    check("abort_oe", sda_oe, 0);
    check("abort_busy", busy, 0);

    // repeated START in mid data byte
    i2c_start;
    write_byte(8'h54, a);
    write_byte(8'h26, a);
    mptr = 6;
    for (int i = 0; i < 3; i++) bus_bit(1'($urandom), r);
    i2c_start;
    i2c_stop;
    check("restart_evt", evt_cnt - e0, 0);
    check_regs("abort_regs");
    do_read(1'b0, 8'h00, 2);

    // randomized traffic
    for (int t = 0; t < 24; t++) begin
      if ($urandom_range(0, 1) == 0) begin
        wq = {};
        for (int k = 0; k < $urandom_range(1, 3); k++) wq.push_back(8'($urandom));
        do_write(8'($urandom));
      end else begin
        do_read(1'($urandom), 8'($urandom), $urandom_range(1, 3));
      end
    end
    check_regs("rand_regs");

    // reset while the slave drives the address ACK
    i2c_start;
    for (int i = 7; i >= 0; i--) bus_bit(8'h54 >> i, r);
    sda_m = 1'b1;
    wait_clk(5);
    scl = 1'b1;
    wait_clk(2);
    check("ack_driven", sda_oe, 1);
    #2 rst_n = 1'b0;
    #1 check("rst_async_oe", sda_oe, 0);
    for (int i = 0; i < 16; i++) mregs[i] = 8'h00;
    mptr = 0;
    wait_clk(3);
    scl = 1'b0;
    wait_clk(3);
    check("rst2_busy", busy, 0);
    check_regs("rst2_regs");
    scl = 1'b1;
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(5);
    do_read(1'b0, 8'h00, 1);
    wq = {8'h5C, 8'h3E, 8'h91};
    do_write(8'hFE);
    do_read(1'b1, 8'hFE, 3);

    check("oe_change_scl_high", oe_bad, 0);
    check("wr_evt_width", evt_wide, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
